// File: rtl/rx_ctrl_sequencer.sv
// rx_ctrl_sequencer
//   Applies tuning/rate configuration to the receiver and forwards its
//   decimated I/Q samples through a one-deep holding register. After each
//   configuration change (and after reset), SETTLE_SAMPLES samples are
//   discarded while the receiver settles.
//
// Ports
//   clock, reset                    rising-edge clock, synchronous active-high reset
//   cfg_valid/cfg_ready             config handshake (accepted only in RUN)
//   cfg_freq, cfg_rate              requested frequency (Hz) and rate code
//   rx_freq, rx_rate                registered config driven to the receiver
//   sample_strobe, sample_real/imag receiver sample input
//   out_valid/out_ready, out_real/imag  held output sample handshake
//   busy                            high while settling
//   overrun, overrun_clr            sticky drop flag and its clear
//
// state  | meaning
// -------+--------------------------------------------------------------
// RUN    | config accepted, samples forwarded to the holding register
// SETTLE | config ignored, samples counted down and discarded

module rx_ctrl_sequencer #(
    parameter logic [31:0] DEFAULT_FREQ   = 32'd7074000,
    parameter logic [7:0]  DEFAULT_RATE   = 8'd0,
    parameter int          SETTLE_SAMPLES = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [31:0]        cfg_freq,
    input  logic [7:0]         cfg_rate,
    output logic [31:0]        rx_freq,
    output logic [7:0]         rx_rate,
    input  logic               sample_strobe,
    input  logic signed [23:0] sample_real,
    input  logic signed [23:0] sample_imag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [23:0] out_real,
    output logic signed [23:0] out_imag,
    output logic               busy,
    output logic               overrun,
    input  logic               overrun_clr
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_SAMPLES);

    typedef enum logic {RUN = 1'b0, SETTLE = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [7:0]         cnt, cnt_nxt;
    logic [31:0]        rx_freq_nxt;
    logic [7:0]         rx_rate_nxt;
    logic               out_valid_nxt;
    logic signed [23:0] out_real_nxt, out_imag_nxt;
    logic               overrun_nxt;

    logic cfg_accept, load, drop;

    assign cfg_ready  = (state == RUN);
    assign busy       = (state == SETTLE);
    assign cfg_accept = cfg_valid && cfg_ready;
    // Holding register accepts a new sample if empty or drained this cycle.
    assign load       = sample_strobe && (state == RUN) && (!out_valid || out_ready);
    assign drop       = sample_strobe && (state == RUN) && out_valid && !out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= SETTLE;
            cnt       <= SETTLE_LOAD;
            rx_freq   <= DEFAULT_FREQ;
            rx_rate   <= DEFAULT_RATE;
            out_valid <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rx_freq   <= rx_freq_nxt;
            rx_rate   <= rx_rate_nxt;
            out_valid <= out_valid_nxt;
            out_real  <= out_real_nxt;
            out_imag  <= out_imag_nxt;
            overrun   <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rx_freq_nxt   = rx_freq;
        rx_rate_nxt   = rx_rate;
        out_valid_nxt = out_valid;
        out_real_nxt  = out_real;
        out_imag_nxt  = out_imag;
        overrun_nxt   = overrun;

        unique case (state)
            RUN: begin
                if (cfg_accept) begin
                    rx_freq_nxt = cfg_freq;
                    rx_rate_nxt = cfg_rate;
                    cnt_nxt     = SETTLE_LOAD;
                    state_nxt   = SETTLE;
                end
            end
            SETTLE: begin
                // Guard on cnt != 0 keeps the counter from wrapping.
                if (sample_strobe && (cnt != 8'd0)) begin
                    cnt_nxt = cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state_nxt = RUN;
                    end
                end
            end
            default: state_nxt = SETTLE;
        endcase

        if (load) begin
            out_valid_nxt = 1'b1;
            out_real_nxt  = sample_real;
            out_imag_nxt  = sample_imag;
        end else if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end

        // A drop in the same cycle as a clear wins, so no event is lost.
        if (drop) begin
            overrun_nxt = 1'b1;
        end else if (overrun_clr) begin
            overrun_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_ctrl_sequencer.sv
module tb_rx_ctrl_sequencer;

    logic               clock = 1'b0;
    logic               reset;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [31:0]        cfg_freq;
    logic [7:0]         cfg_rate;
    logic [31:0]        rx_freq;
    logic [7:0]         rx_rate;
    logic               sample_strobe;
    logic signed [23:0] sample_real;
    logic signed [23:0] sample_imag;
    logic               out_valid;
    logic               out_ready;
    logic signed [23:0] out_real;
    logic signed [23:0] out_imag;
    logic               busy;
    logic               overrun;
    logic               overrun_clr;

    int n_checks = 0;
    int n_pass   = 0;

    rx_ctrl_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_freq      (cfg_freq),
        .cfg_rate      (cfg_rate),
        .rx_freq       (rx_freq),
        .rx_rate       (rx_rate),
        .sample_strobe (sample_strobe),
        .sample_real   (sample_real),
        .sample_imag   (sample_imag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_real      (out_real),
        .out_imag      (out_imag),
        .busy          (busy),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Inputs are applied 1 time unit after an edge; outputs are read there too.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [23:0] val);
        sample_strobe = 1'b1;
        sample_real   = val;
        sample_imag   = val ^ 24'h00ffff;
        step();
        sample_strobe = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; cfg_freq = '0; cfg_rate = '0;
        sample_strobe = 1'b0; sample_real = '0; sample_imag = '0;
        out_ready = 1'b0; overrun_clr = 1'b0;
        step(); step();

        check("rst_rx_freq",   rx_freq,   32'd7074000);
        check("rst_rx_rate",   rx_rate,   32'd0);
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_out_real",  out_real,  32'd0);
        check("rst_busy",      busy,      32'd1);
        check("rst_cfg_ready", cfg_ready, 32'd0);
        check("rst_overrun",   overrun,   32'd0);

        // Initial settle: 8 discarded strobes
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            strobe(24'(100 + i));
            check("init_settle_valid", out_valid, 32'd0);
            check("init_settle_busy",  busy,      (i < 7) ? 32'd1 : 32'd0);
        end
        strobe(24'h000123);
        check("first_valid", out_valid, 32'd1);
        check("first_real",  out_real,  32'h000123);
        check("first_imag",  out_imag,  32'h00fedc);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("consume_clears", out_valid, 32'd0);

        // Config accept and ignored config during SETTLE
        cfg_valid = 1'b1; cfg_freq = 32'd14074000; cfg_rate = 8'd1;
        step();
        cfg_valid = 1'b0;
        check("cfg_rx_freq",   rx_freq,   32'd14074000);
        check("cfg_rx_rate",   rx_rate,   32'd1);
        check("cfg_busy",      busy,      32'd1);
        check("cfg_ready_low", cfg_ready, 32'd0);
        cfg_valid = 1'b1; cfg_freq = 32'd999; cfg_rate = 8'd2;
        step();
        cfg_valid = 1'b0;
        check("settle_ignore_freq", rx_freq, 32'd14074000);
        check("settle_ignore_rate", rx_rate, 32'd1);
        for (int i = 0; i < 8; i++) strobe(24'(200 + i));
        check("cfg_settle_valid", out_valid, 32'd0);
        check("cfg_settle_done",  busy,      32'd0);

        // Overrun: second strobe while full is dropped
        strobe(24'h000111);
        check("ovr_first_valid", out_valid, 32'd1);
        check("ovr_first_flag",  overrun,   32'd0);
        strobe(24'h000222);
        check("ovr_held_real", out_real, 32'h000111);
        check("ovr_set",       overrun,  32'd1);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        check("ovr_clr", overrun, 32'd0);
        overrun_clr = 1'b1; strobe(24'h000277); overrun_clr = 1'b0;
        check("ovr_clr_vs_set", overrun, 32'd1);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        check("ovr_clr2", overrun, 32'd0);

        // Drain and reload in the same cycle
        out_ready = 1'b1;
        strobe(24'h000333);
        check("pass_valid",   out_valid, 32'd1);
        check("pass_real",    out_real,  32'h000333);
        check("pass_overrun", overrun,   32'd0);
        step();
        out_ready = 1'b0;
        check("pass_drained", out_valid, 32'd0);

        // Same-cycle config accept and strobe; held sample survives SETTLE
        cfg_valid = 1'b1; cfg_freq = 32'd21074000; cfg_rate = 8'd0;
        strobe(24'h000444);
        cfg_valid = 1'b0;
        check("both_valid",   out_valid, 32'd1);
        check("both_real",    out_real,  32'h000444);
        check("both_busy",    busy,      32'd1);
        check("both_rx_freq", rx_freq,   32'd21074000);
        for (int i = 0; i < 7; i++) strobe(24'(300 + i));
        check("both_settle_busy", busy,     32'd1);
        strobe(24'h000555);
        check("both_settle_done", busy,      32'd0);
        check("hold_thru_settle", out_real,  32'h000444);
        check("hold_valid",       out_valid, 32'd1);
        check("settle_no_ovr",    overrun,   32'd0);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("hold_consumed", out_valid, 32'd0);

        // Reset in the middle of SETTLE
        cfg_valid = 1'b1; cfg_freq = 32'd14074000; cfg_rate = 8'd1;
        step();
        cfg_valid = 1'b0;
        for (int i = 0; i < 3; i++) strobe(24'(400 + i));
        reset = 1'b1; cfg_valid = 1'b1; sample_strobe = 1'b1; step();
        reset = 1'b0; cfg_valid = 1'b0; sample_strobe = 1'b0;
        check("mid_rst_freq",  rx_freq,   32'd7074000);
        check("mid_rst_rate",  rx_rate,   32'd0);
        check("mid_rst_busy",  busy,      32'd1);
        check("mid_rst_valid", out_valid, 32'd0);
        for (int i = 0; i < 8; i++) strobe(24'(500 + i));
        check("post_rst_valid", out_valid, 32'd0);
        check("post_rst_busy",  busy,      32'd0);
        strobe(24'h000666);
        check("post_rst_sample", out_real, 32'h000666);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rx_ctrl_sequencer.md
RX_CTRL_SEQUENCER -- requirements
Module: rx_ctrl_sequencer

Interface
REQ-001 The block SHALL have the parameter DEFAULT_FREQ, default 32'd7074000: rx_freq value after reset, in Hz.
REQ-002 The block SHALL have the parameter DEFAULT_RATE, default 8'd0: rx_rate code after reset (0 = 48k, 1 = 96k).
REQ-003 The block SHALL have the parameter SETTLE_SAMPLES, default 8: decimated samples discarded after each config change; legal range 1..255.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port cfg_valid, input, 1 bit: a config request is present.
REQ-007 The block SHALL have port cfg_ready, output, 1 bit: the block accepts a config this cycle.
REQ-008 The block SHALL have port cfg_freq, input, 32 bits: requested tuning frequency, Hz.
REQ-009 The block SHALL have port cfg_rate, input, 8 bits: requested rate code.
REQ-010 The block SHALL have port rx_freq, output, 32 bits: registered frequency driven to the receiver.
REQ-011 The block SHALL have port rx_rate, output, 8 bits: registered rate code driven to the receiver.
REQ-012 The block SHALL have port sample_strobe, input, 1 bit: single-cycle pulse, receiver sample available, synchronous to clock.
REQ-013 The block SHALL have ports sample_real and sample_imag, input, 24 bits signed each: receiver I/Q sample.
REQ-014 The block SHALL have port out_valid, output, 1 bit: an output sample is held.
REQ-015 The block SHALL have port out_ready, input, 1 bit: the downstream consumes the held sample when high with out_valid.
REQ-016 The block SHALL have ports out_real and out_imag, output, 24 bits signed each: held I/Q sample.
REQ-017 The block SHALL have port busy, output, 1 bit: high while in SETTLE.
REQ-018 The block SHALL have port overrun, output, 1 bit: sticky flag, a sample was dropped while the output was full.
REQ-019 The block SHALL have port overrun_clr, input, 1 bit: clears overrun.

Function
REQ-020 The block SHALL implement the states RUN and SETTLE; cfg_ready SHALL be 1 only in RUN, and busy SHALL be 1 only in SETTLE.
REQ-021 In RUN, a config SHALL be accepted on cfg_valid & cfg_ready; on the next edge rx_freq takes cfg_freq, rx_rate takes cfg_rate, the settle counter loads SETTLE_SAMPLES, and the state becomes SETTLE.
REQ-022 cfg_rate SHALL be passed through unmodified.
REQ-023 In SETTLE, each sample_strobe SHALL decrement the counter and discard the sample; the strobe that brings the counter from 1 to 0 SHALL move the state to RUN on the same edge, and that sample SHALL also be discarded.
REQ-024 In SETTLE, cfg_valid SHALL be ignored, and rx_freq and rx_rate SHALL be held.
REQ-025 In RUN, on sample_strobe, if out_valid=0, or out_valid=1 with out_ready=1 in the same cycle, the sample SHALL be loaded into out_real/out_imag and out_valid=1 on the next edge.
REQ-026 In RUN, a sample_strobe arriving while out_valid=1 and out_ready=0 SHALL be dropped, leave the held sample unchanged, and set overrun.
REQ-027 out_valid & out_ready with no load SHALL clear out_valid on the next edge.
REQ-028 A sample held before a config change SHALL remain valid through SETTLE until consumed.
REQ-029 A cycle in RUN with both config accept and sample_strobe SHALL forward the sample (subject to REQ-025/026) and then enter SETTLE.
REQ-030 When overrun_clr and an overrun event coincide, overrun SHALL be 1.
REQ-031 Latency SHALL be: sample_strobe to out_valid = 1 cycle; config accept to rx_freq/rx_rate update = 1 cycle.
REQ-032 The settle counter SHALL be 8 bits and SHALL never wrap; a strobe at count 0 cannot occur in SETTLE.

Reset
REQ-033 On reset=1 at a clock edge, the block SHALL set state=SETTLE, counter=SETTLE_SAMPLES, rx_freq=DEFAULT_FREQ, rx_rate=DEFAULT_RATE, out_valid=0, out_real=out_imag=0, overrun=0, and cfg_ready=0.
REQ-034 Reset asserted mid-SETTLE or mid-handshake SHALL override all other inputs that cycle, and any pending config SHALL be lost.

Verification
REQ-035 Reset release, then 8 strobes (default params) -> all 8 discarded with out_valid=0, busy falls after the 8th; the 9th strobe with value 0x000123 gives out_valid=1 and out_real=0x000123 one cycle later.
REQ-036 In RUN, cfg_freq=14074000 and cfg_rate=1 accepted -> next cycle rx_freq=14074000, rx_rate=1, busy=1, cfg_ready=0; a cfg_valid during SETTLE is not accepted.
REQ-037 out_ready=0, two strobes in RUN -> first sample held, second dropped, overrun=1; overrun_clr -> overrun=0.
REQ-038 Same-cycle config accept and strobe with out_valid=0 -> sample forwarded, next 8 strobes discarded.
REQ-039 Reset pulse after 3 of 8 settle strobes, with rx_freq previously updated -> rx_freq=7074000, and 8 further strobes are discarded.
REQ-040 out_valid=1 with out_ready=1 and a strobe in the same cycle -> new sample loaded, out_valid stays 1, no overrun.
